// File: rtl/npu_pkg.sv
// Shared NPU types and constants for the convolution post-processing path.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package npu_pkg;

    localparam int IMG_WIDTH   = 32;
    localparam int IMG_HEIGHT  = 32;
    localparam int KERNEL_SIZE = 3;

    typedef logic signed [21:0] conv_res_t;
    typedef logic [7:0]         pix_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Larger of two unsigned pixels
    function automatic pix_t pix_max(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/relu_maxpool_2d_relu_quant.sv
// ReLU + requantization: negative -> 0, else arithmetic shift right and clamp to pix_t.
// Latency: 1 clk (registered q/q_valid/sat_flag).
// Backpressure: none; every valid input produces a valid output the next cycle.
module relu_quant
    import npu_pkg::*;
#(
    parameter int IN_DW = 22,
    parameter int SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_DW-1:0] conv_data,
    input  logic                    conv_valid,
    output pix_t                    q,
    output logic                    q_valid,
    output logic                    sat_flag
);

    localparam logic [IN_DW-1:0] PIX_MAX = IN_DW'((2 ** $bits(pix_t)) - 1);

    logic             is_neg;
    logic [IN_DW-1:0] shifted;

    // Only non-negative values reach the shifter, so a logical shift is exact
    assign is_neg  = conv_data[IN_DW-1];
    assign shifted = $unsigned(conv_data) >> SHIFT;

    // Register the clamped pixel; sat_flag marks samples that hit the upper clamp
    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= '0;
            q_valid  <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            q_valid  <= conv_valid;
            sat_flag <= conv_valid && !is_neg && (shifted > PIX_MAX);
            if (conv_valid) begin
                if (is_neg)
                    q <= '0;
                else if (shifted > PIX_MAX)
                    q <= '1;
                else
                    q <= shifted[$bits(pix_t)-1:0];
            end
        end
    end

endmodule

// File: rtl/relu_maxpool_2d.sv
// ReLU/requant then 2x2 stride-2 max pooling of a raster conv stream; optional clamp counter (RMP_SAT_CNT_EN).
// Latency: pool_valid 2 clk after the beat carrying a window's bottom-right sample.
// Backpressure: none; conv_valid gaps freeze the pipeline counters, beats outside RUN are dropped.
module relu_maxpool_2d
    import npu_pkg::*;
#(
    parameter int IN_W   = IMG_WIDTH - KERNEL_SIZE + 1,
    parameter int IN_H   = IMG_HEIGHT - KERNEL_SIZE + 1,
    parameter int IN_DW  = 22,
    parameter int OUT_DW = 8,
    parameter int SHIFT  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_signal,
    input  logic signed [IN_DW-1:0] conv_data,
    input  logic                    conv_valid,
    output logic [OUT_DW-1:0]       pool_out,
    output logic                    pool_valid,
    output logic                    pool_row_end,
`ifdef RMP_SAT_CNT_EN
    output logic [15:0]             sat_count,
`endif
    output logic                    done_signal
);

    localparam int PW     = IN_W / 2;
    localparam int PH     = IN_H / 2;
    localparam int CW     = $clog2(IN_W);
    localparam int RW     = $clog2(IN_H);
    localparam int NBEATS = IN_W * IN_H;
    localparam int NW     = $clog2(NBEATS + 1);

    state_t          state;
    logic [NW-1:0]   in_cnt;
    logic            accept;
    logic            start_acc;
    pix_t            q;
    logic            q_valid;
    logic            sat_flag;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            frame_end;
    logic            in_win;
    pix_t            hold;
    pix_t            rowbuf [PW];
    pix_t            pair_max;

    // Beats are taken only in RUN and only until a full frame has been seen
    assign start_acc = (state == IDLE) && start_signal;
    assign accept    = (state == RUN) && conv_valid && (in_cnt != NW'(NBEATS));
    assign in_win    = (col < CW'(2 * PW)) && (row < RW'(2 * PH));
    assign pair_max  = pix_max(hold, q);
    assign done_signal = (state == DONE);

    relu_quant #(
        .IN_DW (IN_DW),
        .SHIFT (SHIFT)
    ) u_relu_quant (
        .clk        (clk),
        .rst        (rst),
        .conv_data  (conv_data),
        .conv_valid (accept),
        .q          (q),
        .q_valid    (q_valid),
        .sat_flag   (sat_flag)
    );

    // Frame sequencing: leave RUN once the final pooled pixel is on the output
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start_signal) state <= RUN;
                RUN:     if (frame_end) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Count accepted input beats so trailing beats past the frame are dropped
    always_ff @(posedge clk) begin
        if (rst || start_acc)
            in_cnt <= '0;
        else if (accept)
            in_cnt <= in_cnt + 1'b1;
    end

    // Raster position of the sample currently leaving the Q stage
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            col       <= '0;
            row       <= '0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= q_valid && (col == CW'(IN_W - 1)) && (row == RW'(IN_H - 1));
            if (q_valid) begin
                if (col == CW'(IN_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IN_H - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Pooling: even rows park pair maxima in rowbuf, odd rows finish the window
    always_ff @(posedge clk) begin
        if (rst) begin
            hold         <= '0;
            pool_out     <= '0;
            pool_valid   <= 1'b0;
            pool_row_end <= 1'b0;
            for (int i = 0; i < PW; i++)
                rowbuf[i] <= '0;
        end else begin
            pool_valid   <= 1'b0;
            pool_row_end <= 1'b0;
            if (q_valid) begin
                if (!col[0]) begin
                    hold <= q;
                end else if (in_win) begin
                    if (!row[0]) begin
                        rowbuf[col[CW-1:1]] <= pair_max;
                    end else begin
                        pool_out     <= pix_max(rowbuf[col[CW-1:1]], pair_max);
                        pool_valid   <= 1'b1;
                        pool_row_end <= (col[CW-1:1] == (CW-1)'(PW - 1));
                    end
                end
            end
        end
    end

`ifdef RMP_SAT_CNT_EN
    // Count upper-clamped samples in the current frame, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst || start_acc)
            sat_count <= '0;
        else if (q_valid && sat_flag && (sat_count != 16'hFFFF))
            sat_count <= sat_count + 16'd1;
    end
`else
    logic unused_sat_flag;
    assign unused_sat_flag = sat_flag;
`endif

endmodule

// File: tb/tb_relu_maxpool_2d.sv
// Self-checking bench for relu_maxpool_2d: constant-frame table, window, gaps, reset abort.
// Latency: checks 2 clk from bottom-right beat to pool_valid.
// Backpressure: exercises random conv_valid gaps and dropped beats.
module tb_relu_maxpool_2d;

    localparam int W  = 30;
    localparam int H  = 30;
    localparam int N  = W * H;
    localparam int NP = (W / 2) * (H / 2);

    logic               clk = 1'b0;
    logic               rst;
    logic               start_signal;
    logic signed [21:0] conv_data;
    logic               conv_valid;
    logic [7:0]         pool_out;
    logic               pool_valid;
    logic               pool_row_end;
    logic               done_signal;
`ifdef RMP_SAT_CNT_EN
    logic [15:0]        sat_count;
`endif

    relu_maxpool_2d dut (
        .clk          (clk),
        .rst          (rst),
        .start_signal (start_signal),
        .conv_data    (conv_data),
        .conv_valid   (conv_valid),
        .pool_out     (pool_out),
        .pool_valid   (pool_valid),
        .pool_row_end (pool_row_end),
`ifdef RMP_SAT_CNT_EN
        .sat_count    (sat_count),
`endif
        .done_signal  (done_signal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int out_q[$];
    int out_cyc[$];
    int br_cyc[$];
    int exp_q[$];
    int row_end_cnt;
    int done_cnt;
    int done_cyc;
    int frame[N];

    typedef struct {
        int val;
        int exp_pix;
        int exp_sat;
    } vec_t;
    vec_t vecs[8];

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (pool_valid) begin
            out_q.push_back(int'(pool_out));
            out_cyc.push_back(cyc);
            if (pool_row_end) row_end_cnt++;
        end
        if (done_signal) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int quant(input int v);
        int s;
        if (v < 0) return 0;
        s = v >>> 4;
        return (s > 255) ? 255 : s;
    endfunction

    function automatic void build_expected();
        int m;
        exp_q.delete();
        for (int pr = 0; pr < H / 2; pr++)
            for (int pc = 0; pc < W / 2; pc++) begin
                m = 0;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (quant(frame[(2 * pr + dr) * W + 2 * pc + dc]) > m)
                            m = quant(frame[(2 * pr + dr) * W + 2 * pc + dc]);
                exp_q.push_back(m);
            end
    endfunction

    task automatic clear_mon();
        out_q.delete();
        out_cyc.delete();
        br_cyc.delete();
        row_end_cnt = 0;
        done_cnt    = 0;
        done_cyc    = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a frame and stream it; gap_pct inserts idle cycles, extra appends surplus beats
    task automatic run_frame(input int gap_pct, input int extra, input int start_at);
        int idx;
        clear_mon();
        start_signal = 1'b1;
        tick();
        start_signal = 1'b0;
        idx = 0;
        while (idx < N + extra) begin
            start_signal = (idx == start_at);
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                conv_valid = 1'b0;
            end else begin
                conv_valid = 1'b1;
                conv_data  = 22'(frame[(idx < N) ? idx : 0]);
                if (idx < N && ((idx / W) % 2 == 1) && ((idx % W) % 2 == 1))
                    br_cyc.push_back(cyc);
                idx++;
            end
            tick();
        end
        conv_valid   = 1'b0;
        start_signal = 1'b0;
        for (int k = 0; k < 20 && done_cnt == 0; k++) tick();
        repeat (3) tick();
    endtask

    task automatic check_frame(input string tag);
        int mism;
        int last;
        build_expected();
        check({tag, "_count"}, out_q.size(), NP);
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= out_q.size() || out_q[i] != exp_q[i]) mism++;
        check({tag, "_data_mismatches"}, mism, 0);
        check({tag, "_row_ends"}, row_end_cnt, H / 2);
        check({tag, "_done_pulses"}, done_cnt, 1);
        last = (out_cyc.size() > 0) ? out_cyc[out_cyc.size() - 1] : -100;
        check({tag, "_done_cycle"}, done_cyc, last + 1);
    endtask

    task automatic check_latency(input string tag);
        int bad;
        bad = 0;
        if (out_cyc.size() != br_cyc.size()) bad = -1;
        else
            for (int i = 0; i < out_cyc.size(); i++)
                if (out_cyc[i] - br_cyc[i] != 2) bad++;
        check({tag, "_latency_mismatches"}, bad, 0);
    endtask

    initial begin
        rst          = 1'b1;
        start_signal = 1'b0;
        conv_valid   = 1'b0;
        conv_data    = '0;
        clear_mon();

        vecs[0] = '{160,    10,  0};
        vecs[1] = '{-500,   0,   0};
        vecs[2] = '{100000, 255, 900};
        vecs[3] = '{0,      0,   0};
        vecs[4] = '{4095,   255, 0};
        vecs[5] = '{4096,   255, 900};
        vecs[6] = '{15,     0,   0};
        vecs[7] = '{-1,     0,   0};

        repeat (3) tick();
        check("rst_pool_out", int'(pool_out), 0);
        check("rst_pool_valid", int'(pool_valid), 0);
        check("rst_row_end", int'(pool_row_end), 0);
        check("rst_done", int'(done_signal), 0);
`ifdef RMP_SAT_CNT_EN
        check("rst_sat_count", int'(sat_count), 0);
`endif
        rst = 1'b0;
        tick();

        // Constant frames from the table
        for (int v = 0; v < 8; v++) begin
            int bad;
            for (int i = 0; i < N; i++) frame[i] = vecs[v].val;
            run_frame(0, 0, -1);
            check($sformatf("const%0d_count", v), out_q.size(), NP);
            bad = 0;
            foreach (out_q[i]) if (out_q[i] != vecs[v].exp_pix) bad++;
            check($sformatf("const%0d_value_mismatches", v), bad, 0);
            check($sformatf("const%0d_row_ends", v), row_end_cnt, H / 2);
            check($sformatf("const%0d_done_pulses", v), done_cnt, 1);
`ifdef RMP_SAT_CNT_EN
            check($sformatf("const%0d_sat_count", v), int'(sat_count), vecs[v].exp_sat);
`endif
        end

        // Single non-zero window in the top-left corner
        for (int i = 0; i < N; i++) frame[i] = 0;
        frame[0] = 16; frame[1] = 64; frame[W] = 32; frame[W + 1] = 48;
        run_frame(0, 0, -1);
        check_frame("win0");
        check("win0_first", (out_q.size() > 0) ? out_q[0] : -1, 4);
        check("win0_second", (out_q.size() > 1) ? out_q[1] : -1, 0);

        // Random data with gaps and surplus beats, then the same data gap-free
        for (int i = 0; i < N; i++) frame[i] = int'($urandom_range(0, 8000)) - 2000;
        run_frame(30, 5, -1);
        check_frame("gaps");
        check_latency("gaps");
        run_frame(0, 0, -1);
        check_frame("nogaps");
        check_latency("nogaps");

        // Beats between frames are dropped
        clear_mon();
        conv_data  = 22'sd100000;
        conv_valid = 1'b1;
        repeat (20) tick();
        conv_valid = 1'b0;
        repeat (4) tick();
        check("idle_beats_outputs", out_q.size(), 0);

        // Abort a frame with reset after 400 beats
        start_signal = 1'b1;
        tick();
        start_signal = 1'b0;
        conv_valid   = 1'b1;
        conv_data    = 22'sd3000;
        repeat (400) tick();
        rst = 1'b1;
        tick();
        clear_mon();
        tick();
        rst        = 1'b0;
        conv_valid = 1'b0;
        repeat (6) tick();
        check("abort_outputs", out_q.size(), 0);
        check("abort_done", done_cnt, 0);

        // Fresh frame after abort, with a stray start pulse mid-run
        for (int i = 0; i < N; i++) frame[i] = int'($urandom_range(0, 6000)) - 1000;
        run_frame(0, 0, 300);
        check_frame("post_rst");
        check_latency("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
